delay_align_ctrl: RTL and testbench
===================================

# delay_align_ctrl

Controller and owner of one 32-entry circular delay line used to align luma/chroma or sync paths in the composite video pipeline. It accepts latency changes over a valid/ready config port and applies them only on a line-start strobe, so timing changes land in blanking. While the delay line holds stale or misaligned samples, it blanks the output. It sits between the register/config block and the video datapath, wrapping `delayfifo32` as its storage.

## Interface
- `BIT_WIDTH`, 8: sample width.
- `BLANK_VALUE`, 0: value driven on `out` while muted.
- `RESET_LATENCY`, 0: latency setting after reset (0..31).

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  a new latency is offered.
- `cfg_ready`  out  1  controller can accept a latency.
- `cfg_latency`  in  5  requested latency setting L.
- `apply_strobe`  in  1  single-cycle line-start pulse; the only point where a latency change may take effect.
- `in`  in  BIT_WIDTH  input sample, one per clock.
- `out`  out  BIT_WIDTH  delayed sample or `BLANK_VALUE`.
- `out_valid`  out  1  `out` carries correctly delayed data.
- `cur_latency`  out  5  latency setting currently driving the delay line.
- `busy`  out  1  a change is pending or a flush is running.

## Operation
- States are IDLE, PENDING and FLUSH.
- **Reset:** enter FLUSH with the counter at 33+`RESET_LATENCY`. Reset outputs:
  - `cur_latency` = `RESET_LATENCY`
  - `out` = `BLANK_VALUE`, `out_valid` = 0
  - `cfg_ready` = 0, `busy` = 1
- `cfg_ready` = (state != FLUSH). A config word is accepted when `cfg_valid` and `cfg_ready` are both high.
- **IDLE:**
  - Accept with `cfg_latency` == `cur_latency`: the word is consumed and nothing else changes.
  - Any other accept: latch the value into `pending_lat` and go to PENDING.
  - `apply_strobe` in IDLE is ignored.
  - An accept in the same cycle as a strobe goes to PENDING; that strobe does not apply it.
- **PENDING:**
  - An accept overwrites `pending_lat`; newest value wins.
  - On `apply_strobe`:
    - Load `cur_latency` with the applied value. If an accept happens in the same cycle, the incoming `cfg_latency` is applied and the old pending value is discarded.
    - Load the counter with 33+new L and go to FLUSH.
    - If the applied value equals `cur_latency`, return to IDLE with no flush.
- **FLUSH:**
  - The counter decrements every cycle. When it is 0, go to IDLE. FLUSH therefore lasts exactly 34+L cycles.
  - `cfg_valid` is back-pressured and `apply_strobe` is ignored.
  - 34+L covers the worst case: the delay-line index runs up to 31, wraps, reaches L, then completes one full L+1 period of fresh writes.
- **Output register:**
  - `out` <= (state != FLUSH) ? delay-line output : `BLANK_VALUE`.
  - `out_valid` <= (state != FLUSH).
- `busy` = (state != IDLE).
- The flush counter is 7 bits wide (max 64). Latency arithmetic is unsigned and never wraps.

## Timing
- **Steady-state latency:** `in` sampled at edge t appears on `out` after edge t+L+2. That is L+1 cycles in the delay line plus 1 output register.
- `cur_latency` changes on the edge that samples `apply_strobe`. The delay line sees the new L from that edge.
- `out_valid` falls one edge after FLUSH is entered and rises one edge after FLUSH exits.
- After an apply at edge e, `out_valid` is low for edges e+1 .. e+34+L and high again at edge e+35+L.
- `cfg_ready` is combinational from state, with no combinational path from `cfg_valid`.
- Reset asserted mid-flush or mid-pending discards all pending state and re-enters the reset FLUSH.

## Structure
- Package `delay_ctrl_pkg` holds:
  - typedef enum `dctl_state_t` {IDLE, PENDING, FLUSH}
  - `LAT_W` = 5, `DELAY_DEPTH` = 32, `FLUSH_BASE` = 33, `FLUSH_CNT_W` = 7
- Single sub-module `delayfifo32` (`BIT_WIDTH` passed through), with its latency input driven by `cur_latency`. It has no reset; the reset flush covers its unreset contents.

## Test plan
- **Reset, `RESET_LATENCY`=4:** release `rst_n`, drive a counting ramp on `in`. `out_valid` stays 0 for 38 cycles. Then `out` equals `in` delayed 6 cycles, and `cfg_ready`=1.
- **Change 4->10:** accept with no strobe, then `busy`=1 and L stays 4. Strobe at edge e: `cur_latency`=10 at e, `out_valid` low for e+1..e+44, then the ramp is delayed 12 with no gap or duplicate.
- **Overwrite in PENDING:** accept 7, then 20, then strobe. `cur_latency`=20 and the flush lasts 54 cycles.
- **Same value:** accept L=`cur_latency`. State stays IDLE, `out_valid` never drops, and a following strobe does nothing.
- **Simultaneous events:** accept 2 in PENDING(9) on the strobe cycle, so L=2 with a 36-cycle flush. Then during FLUSH, hold `cfg_valid` high with 15: `cfg_ready`=0 until flush ends, then the value is accepted.
- **Boundaries and reset:** L=0 gives a 2-cycle delay and a 34-cycle flush; L=31 gives a 33-cycle delay and a 65-cycle flush. Asserting `rst_n` mid-flush restarts the reset flush.

Source files
------------

// File: rtl/delay_ctrl_pkg.sv
// Shared types and constants for the delay-line alignment controller.
// Imported by the controller top and its delay-line storage.
package delay_ctrl_pkg;

  localparam int LAT_W       = 5;
  localparam int DELAY_DEPTH = 32;
  localparam int FLUSH_BASE  = 33;
  localparam int FLUSH_CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    FLUSH
  } dctl_state_t;

  function automatic logic [FLUSH_CNT_W-1:0] flush_len(
    input logic [LAT_W-1:0] lat
  );
    return FLUSH_CNT_W'(FLUSH_BASE) + FLUSH_CNT_W'(lat);
  endfunction

endpackage

// File: rtl/delayfifo32.sv
// 32-entry circular delay line, L+1 cycles from din_i to dout_o.
// Unreset storage; the controller blanks its output until refilled.
import delay_ctrl_pkg::*;

module delayfifo32 #(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic [BIT_WIDTH-1:0] din_i,
  input  logic [LAT_W-1:0]     lat_i,
  output logic [BIT_WIDTH-1:0] dout_o
);

  logic [BIT_WIDTH-1:0] mem_q [DELAY_DEPTH];
  logic [LAT_W-1:0]     wp_q;
  logic [LAT_W-1:0]     rd_idx;
  logic [BIT_WIDTH-1:0] dout_q;

  // Read sees the pre-write contents, so L=31 reads the slot being replaced.
  assign rd_idx = wp_q - lat_i - LAT_W'(1);

  always_ff @(posedge clk) begin
    mem_q[wp_q] <= din_i;
    wp_q        <= wp_q + LAT_W'(1);
    dout_q      <= mem_q[rd_idx];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/delay_align_ctrl.sv
// Latency controller owning a 32-entry delay line: applies changes on
// line-start strobes and blanks the output while the line refills.
import delay_ctrl_pkg::*;

module delay_align_ctrl #(
  parameter int unsigned          BIT_WIDTH     = 8,
  parameter logic [BIT_WIDTH-1:0] BLANK_VALUE   = '0,
  parameter int unsigned          RESET_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LAT_W-1:0]     cfg_latency,
  input  logic                 apply_strobe,
  input  logic [BIT_WIDTH-1:0] in,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic [LAT_W-1:0]     cur_latency,
  output logic                 busy
);

  localparam logic [LAT_W-1:0] RST_LAT = LAT_W'(RESET_LATENCY);

  dctl_state_t            state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0]       cur_q, cur_d;
  logic [LAT_W-1:0]       pend_q, pend_d;
  logic [BIT_WIDTH-1:0]   out_q, out_d;
  logic                   ov_q, ov_d;
  logic [BIT_WIDTH-1:0]   dl_out;
  logic                   accept;
  logic [LAT_W-1:0]       applied;

  delayfifo32 #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_line (
    .clk   (clk),
    .din_i (in),
    .lat_i (cur_q),
    .dout_o(dl_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      cnt_q   <= flush_len(RST_LAT);
      cur_q   <= RST_LAT;
      pend_q  <= '0;
      out_q   <= BLANK_VALUE;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign accept  = cfg_valid & cfg_ready;
  // A word arriving with the strobe supersedes the one already pending.
  assign applied = accept ? cfg_latency : pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (accept && cfg_latency != cur_q) begin
          pend_d  = cfg_latency;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (apply_strobe) begin
          if (applied != cur_q) begin
            cur_d   = applied;
            cnt_d   = flush_len(applied);
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          pend_d = cfg_latency;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = flush_len(cur_q);
      end
    endcase
  end

  always_comb begin
    cfg_ready = (state_q != FLUSH);
    busy      = (state_q != IDLE);
    ov_d      = (state_q != FLUSH);
    out_d     = ov_d ? dl_out : BLANK_VALUE;
  end

  assign out         = out_q;
  assign out_valid   = ov_q;
  assign cur_latency = cur_q;

endmodule

// File: tb/tb_delay_align_ctrl.sv
// Bench for delay_align_ctrl: random samples and config traffic
// checked against an edge-timeline model of the latency rules.
module tb_delay_align_ctrl;

  localparam int          RL    = 4;
  localparam logic [7:0]  BLANK = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [4:0] cfg_latency = '0;
  logic       apply_strobe = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       out_valid;
  logic [4:0] cur_latency;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int idle_edge = 0;
  int m_lat = RL;
  int m_pend = -1;
  bit m_acc = 1'b0;
  logic [7:0] hist [0:4095];

  always #5 clk = ~clk;

  delay_align_ctrl #(
    .BIT_WIDTH    (8),
    .BLANK_VALUE  (BLANK),
    .RESET_LATENCY(RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_latency (cfg_latency),
    .apply_strobe(apply_strobe),
    .in          (din),
    .out         (dout),
    .out_valid   (out_valid),
    .cur_latency (cur_latency),
    .busy        (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Model: flush entered at edge e with latency L ends (state IDLE)
  // at edge e+34+L; output delay is L+2 edges once valid.
  task automatic tick(input bit v, input int l, input bit s);
    bit   fb;
    bit   e_ov;
    int   e_out;
    int   ap;
    cfg_valid    = v;
    cfg_latency  = 5'(l);
    apply_strobe = s;
    din          = 8'($urandom);
    @(posedge clk);
    cyc++;
    hist[cyc % 4096] = din;
    fb   = (cyc <= idle_edge);
    e_ov = !fb;
    e_out = BLANK;
    if (e_ov) e_out = hist[(cyc - m_lat - 2) % 4096];
    m_acc = v && !fb;
    if (!fb) begin
      if (m_pend < 0) begin
        if (m_acc && l != m_lat) m_pend = l;
      end else if (s) begin
        ap = m_acc ? l : m_pend;
        m_pend = -1;
        if (ap != m_lat) begin
          m_lat     = ap;
          idle_edge = cyc + 34 + ap;
        end
      end else if (m_acc) begin
        m_pend = l;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out", 32'(dout), 32'(e_out));
    chk("cur_latency", 32'(cur_latency), 32'(m_lat));
    chk("cfg_ready", 32'(cfg_ready), 32'(cyc >= idle_edge));
    chk("busy", 32'(busy),
        32'((cyc < idle_edge) || (m_pend >= 0)));
  endtask

  task automatic do_reset();
    cfg_valid    = 1'b0;
    apply_strobe = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("rst_out", 32'(dout), 32'(BLANK));
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cur_latency", 32'(cur_latency), 32'(RL));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    m_lat     = RL;
    m_pend    = -1;
    idle_edge = cyc + 34 + RL;
  endtask

  initial begin
    int guard;
    #1;
    do_reset();
    // config noise and strobes during the reset flush are ignored
    repeat (30)
      tick(1'($urandom_range(0, 1)), $urandom_range(0, 31),
           1'($urandom_range(0, 1)));
    repeat (20) tick(0, 0, 0);
    // 4 -> 10
    tick(1, 10, 0);
    repeat (3) tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (50) tick(0, 0, 0);
    // overwrite while pending
    tick(1, 7, 0);
    tick(0, 0, 0);
    tick(1, 20, 0);
    tick(0, 0, 1);
    chk("overwrite_lat", 32'(cur_latency), 32'd20);
    repeat (60) tick(0, 0, 0);
    // same value
    tick(1, 20, 0);
    tick(0, 0, 1);
    repeat (4) tick(0, 0, 0);
    // accept on strobe cycle, then held cfg_valid during flush
    tick(1, 9, 0);
    tick(0, 0, 0);
    tick(1, 2, 1);
    chk("simul_lat", 32'(cur_latency), 32'd2);
    guard = 0;
    do begin
      tick(1, 15, 0);
      guard++;
    end while (!m_acc && guard < 100);
    chk("hold_accept_in_bound", 32'(m_acc), 32'd1);
    tick(0, 0, 1);
    repeat (55) tick(0, 0, 0);
    // boundaries
    tick(1, 0, 0);
    tick(0, 0, 1);
    repeat (40) tick(0, 0, 0);
    tick(1, 31, 0);
    tick(0, 0, 1);
    repeat (70) tick(0, 0, 0);
    // random traffic
    repeat (300)
      tick(1'($urandom_range(0, 7) == 0), $urandom_range(0, 31),
           1'($urandom_range(0, 15) == 0));
    repeat (70) tick(0, 0, 0);
    // reset mid-flush
    tick(1, 12, 0);
    tick(0, 0, 1);
    repeat (10) tick(0, 0, 0);
    do_reset();
    repeat (45) tick(0, 0, 0);
    // reset mid-pending
    tick(1, 3, 0);
    tick(0, 0, 0);
    do_reset();
    repeat (45) tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (5) tick(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
